// File: rtl/data_memory.sv
// data_memory: RV32 load/store data memory behind a request/response handshake.
// Supports byte/half/word accesses selected by funct3, with sign or zero extension on loads.
// WAIT_STATES adds fixed latency between accepting a request and performing the access.
// Optional feature: define DATA_MEMORY_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into error responses. Without it, the low address bits are forced to alignment.
module data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           input_data,
    output logic [31:0]           output_data,
    output logic                  resp_valid,
    output logic                  error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LOW_W = IDX_W + 2;
    localparam logic [3:0]  WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_wcnt;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [LOW_W-1:0]  r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_out;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_err;
    logic [31:0]       w_rword;
    logic [31:0]       w_rshift;
    logic [31:0]       w_load;
    logic [3:0]        w_bmask;
    logic [31:0]       w_wshift;
    logic [31:0]       w_wword;
    logic              w_unused_addr;

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign output_data = r_out;
    assign error       = r_err;

    assign w_accept      = req_valid && req_ready && (write_enable || read_enable);
    assign w_idx         = r_addr[LOW_W-1:2];
    // Address bits above the array span wrap and are intentionally dropped.
    assign w_unused_addr = ^(address >> LOW_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (r_wcnt == '0) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_wcnt <= WS_M1;
        end else if (r_state == S_WAIT && r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 4'd1;
        end
    end

    // Request capture on accept so later input changes have no effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_we     <= write_enable;
            r_funct3 <= funct3;
            r_addr   <= address[LOW_W-1:0];
            r_wdata  <= input_data;
        end
    end

    // Legality, alignment and byte-lane selection for the latched request
    always_comb begin
        w_illegal  = (r_funct3[1:0] == 2'b11) ||
                     (r_we ? r_funct3[2] : (r_funct3[2] && r_funct3[1]));
        w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        w_err  = w_illegal || w_misalign;
        w_lane = r_addr[1:0];
`else
        w_err  = w_illegal;
        case (r_funct3[1:0])
            2'b01:   w_lane = {r_addr[1], 1'b0};
            2'b10:   w_lane = 2'b00;
            default: w_lane = r_addr[1:0];
        endcase
`endif
    end

    // Load path: align the addressed lane to bit 0, then extend
    always_comb begin
        w_rword  = r_mem[w_idx];
        w_rshift = w_rword >> {w_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b010:  w_load = w_rshift;
            3'b100:  w_load = {24'd0, w_rshift[7:0]};
            3'b101:  w_load = {16'd0, w_rshift[15:0]};
            default: w_load = '0;
        endcase
    end

    // Store path: merge shifted store data into the existing word by byte mask
    always_comb begin
        case (r_funct3)
            3'b000:  w_bmask = 4'b0001 << w_lane;
            3'b001:  w_bmask = 4'b0011 << w_lane;
            3'b010:  w_bmask = 4'b1111;
            default: w_bmask = 4'b0000;
        endcase
        w_wshift = r_wdata << {w_lane, 3'b000};
        w_wword  = w_rword;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_bmask[i]) w_wword[8*i +: 8] = w_wshift[8*i +: 8];
        end
    end

    // Response registers: updated only on the edge entering RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_out <= '0;
        end else if (r_state == S_ACCESS) begin
            r_err <= w_err;
            if (!r_we) r_out <= w_err ? '0 : w_load;
        end
    end

    // Memory array: not reset; a store commits only on the ACCESS edge
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_we && !w_err) r_mem[w_idx] <= w_wword;
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and randomized checks of data_memory against a byte-array model.
module tb_data_memory;

    localparam int unsigned WS    = 3;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 32;
    localparam int unsigned SPAN  = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0;
    logic [31:0] input_data = '0;
    logic [31:0] output_data;
    logic        resp_valid;
    logic        error;

    int ncmp  = 0;
    int nfail = 0;

    logic [7:0]  mmem [SPAN];
    logic [31:0] last_out = '0;
    logic [31:0] got;

    data_memory #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (AW),
        .WAIT_STATES(WS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .write_enable(write_enable),
        .read_enable (read_enable),
        .funct3      (funct3),
        .address     (address),
        .input_data  (input_data),
        .output_data (output_data),
        .resp_valid  (resp_valid),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned access_bytes(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference load: byte-array read, then sign/zero extension by arithmetic
    function automatic void model_load(input logic [31:0] a, input logic [2:0] f,
                                       output logic [31:0] d, output logic e);
        int unsigned n, ba;
        logic [31:0] v;
        d = '0;
        e = (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
        if (e) return;
        n  = access_bytes(f);
        ba = a % SPAN;
        if (ba % n != 0) begin
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
            e = 1'b1;
            return;
`else
            ba = ba - (ba % n);
`endif
        end
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(mmem[ba + i]) << (8 * i));
        if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        d = v;
    endfunction

    // Reference store: returns error flag, updates the byte array when legal
    function automatic logic model_store(input logic [31:0] a, input logic [2:0] f,
                                         input logic [31:0] d);
        int unsigned n, ba;
        if (f[2] || f[1:0] == 2'b11) return 1'b1;
        n  = access_bytes(f);
        ba = a % SPAN;
        if (ba % n != 0) begin
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
            return 1'b1;
`else
            ba = ba - (ba % n);
`endif
        end
        for (int unsigned i = 0; i < n; i++) mmem[ba + i] = 8'((d >> (8 * i)) & 32'hFF);
        return 1'b0;
    endfunction

    // One full transaction with latency, response, hold and pulse-width checks
    task automatic do_op(input string tag, input logic w, input logic r, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] od);
        logic [31:0] exp_d;
        logic        exp_e;
        int          lat;
        bit          seen;
        @(negedge clk);
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; write_enable = w; read_enable = r;
        funct3 = f; address = a; input_data = d;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin
                req_valid = 1'b0; write_enable = 1'($urandom); read_enable = 1'($urandom);
                funct3 = 3'($urandom); address = $urandom; input_data = $urandom;
            end
            if (resp_valid) seen = 1'b1;
        end
        check({tag, "/latency"}, seen ? 32'(lat) : 32'd0, 32'(3 + WS));
        if (w) begin
            exp_e = model_store(a, f, d);
            exp_d = last_out;
        end else begin
            model_load(a, f, exp_d, exp_e);
            last_out = exp_d;
        end
        check({tag, "/error"}, 32'(error), 32'(exp_e));
        check({tag, "/data"}, output_data, exp_d);
        od = output_data;
        @(posedge clk); #1;
        check({tag, "/pulse"}, {30'd0, resp_valid, req_ready}, 32'b01);
        write_enable = 1'b0; read_enable = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst/ready", 32'(req_ready), 32'd1);
        check("rst/resp", 32'(resp_valid), 32'd0);
        check("rst/error", 32'(error), 32'd0);
        check("rst/data", output_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Fill a 16-word window so every later load has defined contents
        for (int unsigned i = 0; i < 16; i++) do_op("fill", 1'b1, 1'b0, 3'b010, 32'(4 * i), $urandom, got);

        // Word round trip
        do_op("sw8", 1'b1, 1'b0, 3'b010, 32'h8, 32'h8, got);
        do_op("lw8", 1'b0, 1'b1, 3'b010, 32'h8, 32'h0, got);
        check("lw8/const", got, 32'h0000_0008);

        // Byte/half extension
        do_op("sw0", 1'b1, 1'b0, 3'b010, 32'h0, 32'h80FF_7F01, got);
        do_op("lb3", 1'b0, 1'b1, 3'b000, 32'h3, 32'h0, got);
        check("lb3/const", got, 32'hFFFF_FF80);
        do_op("lbu3", 1'b0, 1'b1, 3'b100, 32'h3, 32'h0, got);
        check("lbu3/const", got, 32'h0000_0080);
        do_op("lh2", 1'b0, 1'b1, 3'b001, 32'h2, 32'h0, got);
        check("lh2/const", got, 32'hFFFF_80FF);
        do_op("lhu0", 1'b0, 1'b1, 3'b101, 32'h0, 32'h0, got);
        check("lhu0/const", got, 32'h0000_7F01);

        // Partial stores; SW leaves output_data holding the previous load
        do_op("sw4", 1'b1, 1'b0, 3'b010, 32'h4, 32'hAAAA_AAAA, got);
        check("sw4/hold", got, 32'h0000_7F01);
        do_op("sb5", 1'b1, 1'b0, 3'b000, 32'h5, 32'h11, got);
        do_op("sh6", 1'b1, 1'b0, 3'b001, 32'h6, 32'h2233, got);
        do_op("lw4", 1'b0, 1'b1, 3'b010, 32'h4, 32'h0, got);
        check("lw4/const", got, 32'h2233_11AA);

        // Illegal funct3 and misaligned word load
        do_op("ld011", 1'b0, 1'b1, 3'b011, 32'h4, 32'h0, got);
        check("ld011/const", {got[30:0], error}, 32'h1);
        do_op("st100", 1'b1, 1'b0, 3'b100, 32'h4, 32'hFFFF_FFFF, got);
        do_op("lw2", 1'b0, 1'b1, 3'b010, 32'h2, 32'h0, got);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        check("lw2/const", {got[30:0], error}, 32'h1);
`else
        check("lw2/const", got, 32'h80FF_7F01);
`endif

        // Wrap-around and write priority
        do_op("sw1000", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h5, got);
        do_op("lw0", 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, got);
        check("lw0/const", got, 32'h0000_0005);
        do_op("both", 1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, got);
        check("both/hold", got, 32'h0000_0005);
        do_op("lw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, got);
        check("lw10/const", got, 32'hDEAD_BEEF);

        // req_valid with no enable is not accepted
        @(negedge clk);
        req_valid = 1'b1; write_enable = 1'b0; read_enable = 1'b0; funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("noen", {30'd0, resp_valid, req_ready}, 32'b01);
        end
        req_valid = 1'b0;

        // Reset during WAIT abandons the pending store
        do_op("sw_c", 1'b1, 1'b0, 3'b010, 32'hC, 32'hCAFE_F00D, got);
        @(negedge clk);
        req_valid = 1'b1; write_enable = 1'b1; read_enable = 1'b0;
        funct3 = 3'b010; address = 32'hC; input_data = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0; write_enable = 1'b0;
        check("mid/busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid/rst", {28'd0, error, resp_valid, req_ready, |output_data}, 32'b0010);
        last_out = '0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("mid/noresp", 32'(resp_valid), 32'd0);
        end
        do_op("lw_c", 1'b0, 1'b1, 3'b010, 32'hC, 32'h0, got);
        check("lw_c/const", got, 32'hCAFE_F00D);

        // Randomized traffic in the window, upper address bits scrambled to exercise wrap
        for (int i = 0; i < 80; i++) begin
            int unsigned kind;
            logic [31:0] ra;
            kind = $urandom_range(0, 2);
            ra   = $urandom & 32'hFFFF_F03F;
            case (kind)
                0:       do_op("rnd_ld", 1'b0, 1'b1, 3'($urandom_range(0, 7)), ra, $urandom, got);
                1:       do_op("rnd_st", 1'b1, 1'b0, 3'($urandom_range(0, 7)), ra, $urandom, got);
                default: do_op("rnd_both", 1'b1, 1'b1, 3'($urandom_range(0, 7)), ra, $urandom, got);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
